// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared state encoding and defaults for the CNN operand sequencer.
package cnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, SEND, WAIT_RES, DONE} state_e;
  localparam int N_WORDS_DEF     = 10;
  localparam int WORD_STRIDE     = 4;
  localparam int RES_TIMEOUT_DEF = 255;
endpackage

// File: rtl/cnn_operand_sequencer.sv
// cnn_operand_sequencer: fetches one window of packed operand words, streams them out, then waits for the conv result.
module cnn_operand_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int N_WORDS     = N_WORDS_DEF,
  parameter int RES_TIMEOUT = RES_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic [31:0] op_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_last,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);
  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CW = $clog2(RES_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
  localparam logic [CW-1:0] TMO_CNT  = CW'(RES_TIMEOUT - 1);
  state_e        state_q, state_d;
  logic [31:0]   base_q, base_d, op_data_q, op_data_d, result_q, result_d, mem_addr_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_last_q, op_last_d, tmo_d;
  logic          mem_rd_en_q, op_valid_q, busy_q, done_q, tmo_q;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    op_data_d = op_data_q;
    op_last_d = op_last_q;
    result_d  = result_q;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        base_d  = base_addr;
        idx_d   = '0;
      end
      FETCH: state_d = WAIT_MEM;
      WAIT_MEM: if (mem_rd_valid) begin
        state_d   = SEND;
        op_data_d = mem_rd_data;
        op_last_d = idx_q == LAST_IDX;
      end
      SEND: if (op_ready) begin
        state_d   = op_last_q ? WAIT_RES : FETCH;
        idx_d     = op_last_q ? idx_q : idx_q + IW'(1);
        op_last_d = 1'b0;
        cnt_d     = '0;
      end
      // res_valid is tested first so it wins over a coinciding timeout
      WAIT_RES: if (res_valid) begin
        state_d  = DONE;
        result_d = res_data;
      end else if (cnt_q == TMO_CNT) begin
        state_d = IDLE;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      op_data_q   <= '0;
      op_last_q   <= 1'b0;
      result_q    <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      op_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      op_data_q   <= op_data_d;
      op_last_q   <= op_last_d;
      result_q    <= result_d;
      mem_rd_en_q <= state_d == FETCH;
      mem_addr_q  <= (state_d == FETCH) ? base_d + 32'(WORD_STRIDE) * 32'(idx_d) : mem_addr_q;
      op_valid_q  <= state_d == SEND;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
      tmo_q       <= tmo_d;
    end
  end
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign op_data     = op_data_q;
  assign op_valid    = op_valid_q;
  assign op_last     = op_last_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
endmodule
